// File: rtl/riscv32_imem_loader.sv
// Byte-stream boot loader: assembles a count-prefixed, XOR-protected program
// image into IMEM words and releases the core reset only after a good load.
module riscv32_imem_loader #(
  parameter int IMEM_DEPTH_WORDS = 4096,
  parameter int ADDR_W           = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;       // word count N (low byte first, then completed)
  logic [15:0] k;         // index of the word currently being assembled
  logic [1:0]  byte_idx;  // byte position inside the current word
  logic [23:0] wbuf;      // bytes b0..b2 of the word in progress
  logic [7:0]  xor_acc;   // running XOR of every byte accepted so far

  // reload wins over rx_valid: a byte offered alongside reload is dropped
  logic        accept;
  logic [15:0] cnt_new;
  logic        oversize;
  logic        last_word;
  logic        csum_ok;

  assign accept    = rx_valid && !reload;
  assign cnt_new   = {rx_data, cnt[7:0]};
  assign oversize  = ({1'b0, cnt_new} > DEPTH_L);
  assign last_word = (k == cnt - 16'd1);
  assign csum_ok   = (rx_data == xor_acc);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode from the current state and the accepted byte
  always_comb begin
    state_nxt = state;
    if (reload) begin
      state_nxt = S_IDLE;
    end else if (accept) begin
      case (state)
        S_IDLE:   state_nxt = S_CNT_HI;
        S_CNT_HI: begin
          if (oversize)             state_nxt = S_ERROR;
          else if (cnt_new == '0)   state_nxt = S_CSUM;
          else                      state_nxt = S_DATA;
        end
        S_DATA:   if (byte_idx == 2'd3 && last_word) state_nxt = S_CSUM;
        S_CSUM:   state_nxt = csum_ok ? S_DONE : S_ERROR;
        default:  state_nxt = state;
      endcase
    end
  end

  // Control, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      byte_idx   <= '0;
      xor_acc    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        k          <= '0;
        byte_idx   <= '0;
        xor_acc    <= '0;
        core_rst_n <= 1'b0;
        busy       <= 1'b0;
        load_done  <= 1'b0;
        load_error <= 1'b0;
      end else if (accept) begin
        case (state)
          S_IDLE: begin
            // accumulator is zero on entry to IDLE, so first byte seeds it
            xor_acc  <= rx_data;
            k        <= '0;
            byte_idx <= '0;
            busy     <= 1'b1;
          end
          S_CNT_HI: begin
            xor_acc <= xor_acc ^ rx_data;
            if (oversize) begin
              load_error <= 1'b1;
              busy       <= 1'b0;
            end
          end
          S_DATA: begin
            xor_acc  <= xor_acc ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= k[ADDR_W-1:0];
              imem_wdata <= {rx_data, wbuf};
              k          <= k + 16'd1;
            end
          end
          S_CSUM: begin
            busy <= 1'b0;
            if (csum_ok) begin
              load_done  <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Data capture: count bytes and partial word, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == S_IDLE)   cnt <= {8'h00, rx_data};
      if (state == S_CNT_HI) cnt <= cnt_new;
      if (state == S_DATA) begin
        case (byte_idx)
          2'd0:    wbuf[7:0]   <= rx_data;
          2'd1:    wbuf[15:8]  <= rx_data;
          2'd2:    wbuf[23:16] <= rx_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/riscv32_imem_loader.md
# riscv32_imem_loader

Byte-stream boot loader that writes a program image into the single-cycle core's instruction memory and holds the core in reset until the image has been received and verified. It sits between a byte source (UART receiver or bench driver) and the IMEM write port. Its reset output gates the core's `rst_n`, so the core fetches from PC=0x00000000 only after a good load.

## Interface
Parameters:
- `IMEM_DEPTH_WORDS`, default 4096: maximum number of words accepted.
- `ADDR_W`, default 12: width of the IMEM word address; must satisfy 2^ADDR_W >= IMEM_DEPTH_WORDS.

Ports:
- `clk`  input  1  system clock; all state changes on the posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx_valid`  input  1  a byte is present on `rx_data` this cycle; one byte is consumed per posedge while high.
- `rx_data`  input  8  stream byte.
- `reload`  input  1  synchronous pulse; aborts or restarts loading.
- `imem_we`  output  1  one-cycle IMEM word write strobe.
- `imem_addr`  output  ADDR_W  IMEM word address (byte address >> 2).
- `imem_wdata`  output  32  IMEM write data.
- `core_rst_n`  output  1  active-low reset to the core; high only after a verified load.
- `busy`  output  1  a load is in progress.
- `load_done`  output  1  image received and checksum matched.
- `load_error`  output  1  image rejected.

## Operation
- The stream format, in order:
  - `CNT_LO`, then `CNT_HI`: 16-bit word count N, little-endian.
  - N words, each 4 bytes, little-endian.
  - One checksum byte.
- The checksum is the XOR of every preceding byte, including both count bytes.
- States are IDLE, CNT_HI, DATA, CSUM, DONE and ERROR.
  - IDLE: an accepted byte is `CNT_LO`. Go to CNT_HI and set `busy`.
  - CNT_HI: the accepted byte completes N.
    - If N > IMEM_DEPTH_WORDS, go to ERROR.
    - If N == 0, go to CSUM.
    - Otherwise, go to DATA.
  - DATA: a 2-bit byte index assembles bytes into a word.
    - On the 4th byte, write the word at word index k (0..N-1), then increment k.
    - After word N-1, go to CSUM.
  - CSUM: the accepted byte is compared with the running XOR. Equal goes to DONE; unequal goes to ERROR.
  - DONE: `load_done`=1 and `core_rst_n`=1. Further bytes are ignored.
  - ERROR: `load_error`=1 and `core_rst_n`=0. Further bytes are ignored.
- `reload` has priority over `rx_valid`; a byte offered on the same edge is discarded. From any state, on the next edge `reload`:
  - returns the block to IDLE;
  - clears k, the byte index, the XOR accumulator, `load_done` and `load_error`;
  - drives `core_rst_n`=0.
- The running XOR resets to 0 on entry to IDLE.
- Gaps in `rx_valid` are allowed anywhere and have no effect on state.
- N == IMEM_DEPTH_WORDS is legal. The highest `imem_addr` written is IMEM_DEPTH_WORDS-1, and the address never wraps.
- Words already written before an ERROR or `reload` remain in IMEM and are not cleared.

## Timing
- Reset values:
  - state IDLE;
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0;
  - `core_rst_n`=0, `busy`=0, `load_done`=0, `load_error`=0.
- All outputs are registered. There are no combinational paths from `rx_*` to outputs.
- Word write timing: if the 4th byte of word k is accepted at edge T, then in the cycle after T:
  - `imem_we`=1 for exactly one cycle;
  - `imem_addr`=k;
  - `imem_wdata`={b3,b2,b1,b0}.
- `imem_addr` and `imem_wdata` hold their values until the next write.
- Checksum timing: if the checksum byte is accepted at edge T, then after T `load_done` (or `load_error`) rises together with the `core_rst_n` update, and `busy` falls.
- The last IMEM write always completes at least one edge before `core_rst_n` rises.
- Oversize count: `load_error` rises after the edge that accepts `CNT_HI`.
- `busy`=1 from the edge that accepts `CNT_LO` until the edge that enters DONE or ERROR, or a `reload`.
- Asynchronous `rst_n` assertion mid-load forces all reset values immediately. That includes `core_rst_n`=0.

## Test plan
- Good load: stream 02 00 93 00 a0 00 13 01 40 01 62 with one idle cycle between each byte.
  - Expect the write 0x00a00093 at address 0, then the write 0x01400113 at address 1, each with a single-cycle `imem_we`.
  - Then `load_done`=1, `core_rst_n`=1, `load_error`=0.
- Bad checksum: the same stream with a final byte of 63.
  - Both writes still occur.
  - `load_error`=1 and `core_rst_n` stays 0.
  - A subsequent byte 00 causes no state change.
- Empty image: stream 00 00 00.
  - No `imem_we` pulse.
  - `load_done`=1 after the 3rd byte.
- Oversize count: stream 01 10 (N=4097).
  - `load_error`=1 after the 2nd byte.
  - The following 8 bytes produce no writes.
- Reload mid-word: after 02 00 93 00, pulse `reload` while `rx_valid`=1 with byte a0. That byte is discarded.
  - Then the full good stream writes addresses 0 and 1 correctly and reaches DONE.
- Reload after DONE:
  - `core_rst_n` falls and `load_done` clears one edge after `reload`.
  - `rst_n` asserted mid-DATA returns every output to its reset value asynchronously.
